// File: rtl/spr_unit_pkg.sv
// Shared types and helpers for the SPR execution unit.
package spr_unit_pkg;

  // Widest CR the field-mask helper supports (fields of 4 bits each).
  localparam int CR_FIELDS_MAX = 16;

  typedef enum logic [3:0] {
    OP_CR_AND  = 4'd0,
    OP_CR_OR   = 4'd1,
    OP_CR_XOR  = 4'd2,
    OP_CR_NAND = 4'd3,
    OP_CR_NOR  = 4'd4,
    OP_CR_EQV  = 4'd5,
    OP_CR_ANDC = 4'd6,
    OP_CR_ORC  = 4'd7,
    OP_MCRF    = 4'd8,
    OP_MTCRF   = 4'd9,
    OP_MFCR    = 4'd10,
    OP_MFSPR   = 4'd11,
    OP_MTSPR   = 4'd12,
    OP_MFMSR   = 4'd13,
    OP_MTMSR   = 4'd14
  } spr_op_e;

  // fxm bit j selects CR field (fields-1-j), which lives in CR bits [4j+3:4j],
  // so the mask is just each fxm bit widened to a nibble in place. Callers
  // truncate the result to their CR width.
  function automatic logic [4*CR_FIELDS_MAX-1:0] cr_field_mask(
    input logic [CR_FIELDS_MAX-1:0] fxm
  );
    logic [4*CR_FIELDS_MAX-1:0] mask;
    for (int j = 0; j < CR_FIELDS_MAX; j++) begin
      mask[4*j +: 4] = {4{fxm[j]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/spr_unit_if.sv
// Issue / result handshake bundle between the execute stage and spr_unit.
interface spr_unit_if
  import spr_unit_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int CR_FIELDS = 8,
  parameter int SPR_AW    = 4
);
  logic                 in_valid;
  logic                 in_ready;
  spr_op_e              in_op;
  logic [4:0]           in_sel_a;
  logic [4:0]           in_sel_b;
  logic [4:0]           in_sel_t;
  logic [CR_FIELDS-1:0] in_fxm;
  logic [SPR_AW-1:0]    in_spr;
  logic [DWIDTH-1:0]    in_a;
  logic                 out_valid;
  logic                 out_ready;
  logic [DWIDTH-1:0]    out_res;
  logic                 out_fault;

  modport master (
    output in_valid, in_op, in_sel_a, in_sel_b, in_sel_t, in_fxm, in_spr, in_a,
    output out_ready,
    input  in_ready, out_valid, out_res, out_fault
  );

  modport slave (
    input  in_valid, in_op, in_sel_a, in_sel_b, in_sel_t, in_fxm, in_spr, in_a,
    input  out_ready,
    output in_ready, out_valid, out_res, out_fault
  );
endinterface

// File: rtl/spr_cr_logic.sv
// Combinational next-CR: CR-bit logic, field copy and masked field move.
// CR bit n is cr[DWIDTH-1-n] and field 0 sits in the MSBs, so ascending
// packed views of cr give bit/field indexing directly.
module spr_cr_logic
  import spr_unit_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int CR_FIELDS = 8
) (
  input  spr_op_e              op,
  input  logic [4:0]           sel_a,
  input  logic [4:0]           sel_b,
  input  logic [4:0]           sel_t,
  input  logic [CR_FIELDS-1:0] fxm,
  input  logic [DWIDTH-1:0]    a,
  input  logic [DWIDTH-1:0]    cr,
  output logic [DWIDTH-1:0]    cr_next
);
  logic [0:DWIDTH-1]          cr_bits;
  logic [0:DWIDTH-1]          bits_next;
  logic [0:CR_FIELDS-1][3:0]  cr_flds;
  logic [0:CR_FIELDS-1][3:0]  flds_next;
  logic [DWIDTH-1:0]          mtcrf_mask;
  logic                       bit_a;
  logic                       bit_b;
  logic                       bit_t;

  assign cr_bits    = cr;
  assign cr_flds    = cr;
  assign mtcrf_mask = DWIDTH'(cr_field_mask(CR_FIELDS_MAX'(fxm)));

  // Evaluate every candidate CR update and pick the one for this op.
  always_comb begin
    bit_a = cr_bits[sel_a];
    bit_b = cr_bits[sel_b];
    bit_t = 1'b0;
    case (op)
      OP_CR_AND:  bit_t = bit_a & bit_b;
      OP_CR_OR:   bit_t = bit_a | bit_b;
      OP_CR_XOR:  bit_t = bit_a ^ bit_b;
      OP_CR_NAND: bit_t = ~(bit_a & bit_b);
      OP_CR_NOR:  bit_t = ~(bit_a | bit_b);
      OP_CR_EQV:  bit_t = ~(bit_a ^ bit_b);
      OP_CR_ANDC: bit_t = bit_a & ~bit_b;
      OP_CR_ORC:  bit_t = bit_a | ~bit_b;
      default:    bit_t = 1'b0;
    endcase

    bits_next        = cr_bits;
    bits_next[sel_t] = bit_t;

    // Source is read from the pre-op CR even when it equals the target.
    flds_next              = cr_flds;
    flds_next[sel_t[4:2]]  = cr_flds[sel_a[4:2]];

    cr_next = cr;
    case (op)
      OP_CR_AND, OP_CR_OR, OP_CR_XOR, OP_CR_NAND,
      OP_CR_NOR, OP_CR_EQV, OP_CR_ANDC, OP_CR_ORC: cr_next = bits_next;
      OP_MCRF:  cr_next = flds_next;
      OP_MTCRF: cr_next = (cr & ~mtcrf_mask) | (a & mtcrf_mask);
      default:  cr_next = cr;
    endcase
  end
endmodule

// File: rtl/spr_unit.sv
// Registered SPR execution unit: owns CR, MSR and the SPR bank, executes
// CR logic and CR/GPR/SPR/MSR moves with a one-entry result register.
module spr_unit
  import spr_unit_pkg::*;
#(
  parameter int                 DWIDTH        = 32,
  parameter int                 CR_FIELDS     = 8,
  parameter int                 NUM_SPR       = 16,
  parameter logic [NUM_SPR-1:0] SPR_PRIV_MASK = 16'hfff0,
  parameter int                 PR_BIT        = 14
) (
  input  logic              clk,
  input  logic              reset,
  spr_unit_if.slave         bus,
  output logic [DWIDTH-1:0] cr,
  output logic [DWIDTH-1:0] msr
);
  localparam int SPR_AW = $clog2(NUM_SPR);

  if (DWIDTH != 4*CR_FIELDS) begin : g_width_chk
    $error("spr_unit: DWIDTH must equal 4*CR_FIELDS");
  end
  if (CR_FIELDS > CR_FIELDS_MAX) begin : g_fields_chk
    $error("spr_unit: CR_FIELDS exceeds CR_FIELDS_MAX");
  end

  logic [DWIDTH-1:0] spr_q [NUM_SPR];
  logic [DWIDTH-1:0] cr_next_p0;
  logic [DWIDTH-1:0] spr_rd_p0;
  logic [DWIDTH-1:0] res_p0;
  logic              accept_p0;
  logic              pr_p0;
  logic              spr_oob_p0;
  logic              spr_priv_p0;
  logic              fault_p0;
  logic              op_known_p0;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept_p0    = bus.in_valid && bus.in_ready;
  assign pr_p0        = msr[PR_BIT];

  // Indices past a non-power-of-two bank are never backed by storage.
  assign spr_oob_p0   = (int'(bus.in_spr) >= NUM_SPR);
  assign spr_priv_p0  = spr_oob_p0 ? 1'b1 : SPR_PRIV_MASK[bus.in_spr];
  assign spr_rd_p0    = spr_oob_p0 ? '0 : spr_q[bus.in_spr];

  spr_cr_logic #(
    .DWIDTH    (DWIDTH),
    .CR_FIELDS (CR_FIELDS)
  ) u_cr_logic (
    .op      (bus.in_op),
    .sel_a   (bus.in_sel_a),
    .sel_b   (bus.in_sel_b),
    .sel_t   (bus.in_sel_t),
    .fxm     (bus.in_fxm),
    .a       (bus.in_a),
    .cr      (cr),
    .cr_next (cr_next_p0)
  );

  // Result and privilege fault for the op at the issue port.
  always_comb begin
    res_p0      = bus.in_a;
    fault_p0    = 1'b0;
    op_known_p0 = 1'b1;
    case (bus.in_op)
      OP_CR_AND, OP_CR_OR, OP_CR_XOR, OP_CR_NAND, OP_CR_NOR,
      OP_CR_EQV, OP_CR_ANDC, OP_CR_ORC, OP_MCRF, OP_MTCRF: res_p0 = bus.in_a;
      OP_MFCR:  res_p0 = cr;
      OP_MFSPR: begin
        fault_p0 = spr_oob_p0 || (pr_p0 && spr_priv_p0);
        res_p0   = spr_rd_p0;
      end
      OP_MTSPR: fault_p0 = spr_oob_p0 || (pr_p0 && spr_priv_p0);
      OP_MFMSR: res_p0 = msr;
      OP_MTMSR: fault_p0 = pr_p0;
      default: begin
        res_p0      = 'x;
        op_known_p0 = 1'b0;
      end
    endcase
    if (fault_p0) res_p0 = '0;
  end

  // ---- p0 -> p1: architectural state commits on the accepting edge ----
  // Faulted ops leave CR, MSR and the SPR bank untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cr  <= '0;
      msr <= '0;
      for (int i = 0; i < NUM_SPR; i++) spr_q[i] <= '0;
    end else if (accept_p0 && !fault_p0) begin
      cr <= cr_next_p0;
      if (bus.in_op == OP_MTMSR) msr <= bus.in_a;
      if (bus.in_op == OP_MTSPR) spr_q[bus.in_spr] <= bus.in_a;
    end
  end

  // One-entry result register; contents hold while the consumer stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.out_valid <= 1'b0;
      bus.out_res   <= '0;
      bus.out_fault <= 1'b0;
    end else if (accept_p0) begin
      bus.out_valid <= 1'b1;
      bus.out_res   <= res_p0;
      bus.out_fault <= fault_p0;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Undefined opcodes execute as no-ops; flag them in simulation.
  always_ff @(posedge clk) begin
    if (reset && accept_p0) begin
      assert (op_known_p0) else $error("spr_unit: undefined op %0d", bus.in_op);
    end
  end
endmodule

// File: tb/tb_spr_unit.sv
// Self-checking bench for spr_unit: directed cases plus randomized ops
// against an architectural reference model.
module tb_spr_unit;
  import spr_unit_pkg::*;

  localparam int DW  = 32;
  localparam int NF  = 8;
  localparam int NS  = 16;
  localparam int PRB = 14;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cr;
  logic [31:0] msr;

  int n_checks = 0;
  int n_errors = 0;

  bit [31:0] m_cr;
  bit [31:0] m_msr;
  bit [31:0] m_spr [16];
  bit [15:0] priv_mask = 16'hfff0;
  bit [31:0] exp_res_q [$];
  bit        exp_flt_q [$];
  bit        rand_ready = 1'b0;

  spr_unit_if #(.DWIDTH(DW), .CR_FIELDS(NF), .SPR_AW(4)) bus ();

  spr_unit #(
    .DWIDTH(DW), .CR_FIELDS(NF), .NUM_SPR(NS),
    .SPR_PRIV_MASK(16'hfff0), .PR_BIT(PRB)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .cr(cr), .msr(msr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cr  = '0;
    m_msr = '0;
    foreach (m_spr[i]) m_spr[i] = '0;
    exp_res_q.delete();
    exp_flt_q.delete();
  endtask

  // Architectural effect of one accepted op, from the instruction definitions.
  task automatic model_exec(input spr_op_e op, input bit [4:0] sa, input bit [4:0] sb,
                            input bit [4:0] st, input bit [7:0] fxm, input bit [3:0] sp,
                            input bit [31:0] a);
    bit [31:0] res;
    bit        flt;
    bit        pr;
    bit        ba, bb, bt;
    int        fa, ft;
    res = a;
    flt = 1'b0;
    pr  = m_msr[PRB];
    ba  = m_cr[31 - int'(sa)];
    bb  = m_cr[31 - int'(sb)];
    bt  = 1'b0;
    fa  = int'(sa[4:2]);
    ft  = int'(st[4:2]);
    case (op)
      OP_CR_AND:  bt = ba & bb;
      OP_CR_OR:   bt = ba | bb;
      OP_CR_XOR:  bt = ba ^ bb;
      OP_CR_NAND: bt = !(ba && bb);
      OP_CR_NOR:  bt = !(ba || bb);
      OP_CR_EQV:  bt = (ba == bb);
      OP_CR_ANDC: bt = ba && !bb;
      OP_CR_ORC:  bt = ba || !bb;
      default:    bt = 1'b0;
    endcase
    case (op)
      OP_CR_AND, OP_CR_OR, OP_CR_XOR, OP_CR_NAND,
      OP_CR_NOR, OP_CR_EQV, OP_CR_ANDC, OP_CR_ORC: m_cr[31 - int'(st)] = bt;
      OP_MCRF:  m_cr[31 - 4*ft -: 4] = m_cr[31 - 4*fa -: 4];
      OP_MTCRF: begin
        for (int i = 0; i < 8; i++)
          if (fxm[7-i]) m_cr[31 - 4*i -: 4] = a[31 - 4*i -: 4];
      end
      OP_MFCR:  res = m_cr;
      OP_MFSPR: begin
        flt = pr && priv_mask[sp];
        if (!flt) res = m_spr[sp];
      end
      OP_MTSPR: begin
        flt = pr && priv_mask[sp];
        if (!flt) m_spr[sp] = a;
      end
      OP_MFMSR: res = m_msr;
      OP_MTMSR: begin
        flt = pr;
        if (!flt) m_msr = a;
      end
      default: ;
    endcase
    if (flt) res = '0;
    exp_res_q.push_back(res);
    exp_flt_q.push_back(flt);
  endtask

  // Present one op, wait (bounded) for acceptance, then update the model.
  // Entered after a rising edge; returns 1 time unit after the accepting edge.
  task automatic do_issue(input spr_op_e op, input bit [4:0] sa, input bit [4:0] sb,
                          input bit [4:0] st, input bit [7:0] fxm, input bit [3:0] sp,
                          input bit [31:0] a);
    int guard;
    bit acc;
    guard = 0;
    acc   = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_sel_a = sa;
    bus.in_sel_b = sb;
    bus.in_sel_t = st;
    bus.in_fxm   = fxm;
    bus.in_spr   = sp;
    bus.in_a     = a;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      guard++;
    end
    #1;
    bus.in_valid = 1'b0;
    if (!acc) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(bus.out_valid), 32'd1);
      model_exec(op, sa, sb, st, fxm, sp, a);
      check("cr", cr, m_cr);
      check("msr", msr, m_msr);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_res_q.size() != 0 && g < 50) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain_empty", 32'(exp_res_q.size()), 32'd0);
  endtask

  // Every consumed result is compared with the oldest expected one.
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      if (exp_res_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        check("out_res", bus.out_res, exp_res_q.pop_front());
        check("out_fault", 32'(bus.out_fault), 32'(exp_flt_q.pop_front()));
      end
    end
  end

  // Random consumer back-pressure during the random phase.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    spr_op_e   rop;
    bit [31:0] ra;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_MFCR;
    bus.in_sel_a  = '0;
    bus.in_sel_b  = '0;
    bus.in_sel_t  = '0;
    bus.in_fxm    = '0;
    bus.in_spr    = '0;
    bus.in_a      = '0;
    bus.out_ready = 1'b1;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_res", bus.out_res, 32'd0);
    check("rst_out_fault", 32'(bus.out_fault), 32'd0);
    check("rst_cr", cr, 32'd0);
    check("rst_msr", msr, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reads of reset state
    do_issue(OP_MFCR,  0, 0, 0, 8'h00, 4'd0, 32'h0BAD_0001);
    do_issue(OP_MFMSR, 0, 0, 0, 8'h00, 4'd0, 32'h0BAD_0002);
    do_issue(OP_MFSPR, 0, 0, 0, 8'h00, 4'd3, 32'hFFFF_FFFF);

    // Masked field move
    do_issue(OP_MTCRF, 0, 0, 0, 8'hFF, 4'd0, 32'h1234_5678);
    do_issue(OP_MTCRF, 0, 0, 0, 8'h81, 4'd0, 32'hA000_0005);
    check("mtcrf_cr", cr, 32'hA234_5675);

    // CR bit logic and field copy
    do_issue(OP_MTCRF, 0, 0, 0, 8'hFF, 4'd0, 32'h8000_0000);
    do_issue(OP_CR_XOR, 5'd0, 5'd1, 5'd2, 8'h00, 4'd0, 32'd0);
    check("crxor_cr", cr, 32'hA000_0000);
    do_issue(OP_MCRF, 5'd0, 5'd0, 5'd20, 8'h00, 4'd0, 32'd0);
    check("mcrf_cr", cr, 32'hA000_0A00);

    // Back-to-back SPR write then read
    do_issue(OP_MTSPR, 0, 0, 0, 8'h00, 4'd5, 32'hDEAD_BEEF);
    do_issue(OP_MFSPR, 0, 0, 0, 8'h00, 4'd5, 32'd0);
    check("spr_b2b_res", bus.out_res, 32'hDEAD_BEEF);

    // Stall: blocked issue must not change state, result held
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    do_issue(OP_MTCRF, 0, 0, 0, 8'hFF, 4'd0, 32'h1357_9BDF);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_MTCRF;
    bus.in_fxm   = 8'hFF;
    bus.in_a     = 32'h2468_ACE0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_out_res", bus.out_res, 32'h1357_9BDF);
      check("stall_cr", cr, 32'h1357_9BDF);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    do_issue(OP_MTCRF, 0, 0, 0, 8'hFF, 4'd0, 32'h2468_ACE0);

    // Reset while a result is pending drops it
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    do_issue(OP_MFMSR, 0, 0, 0, 8'h00, 4'd0, 32'd0);
    @(negedge clk);
    check("midrst_pending", 32'(bus.out_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_res", bus.out_res, 32'd0);
    check("midrst_cr", cr, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Privilege: entering problem state, then privileged accesses fault
    do_issue(OP_MTSPR, 0, 0, 0, 8'h00, 4'd4, 32'h1111_2222);
    do_issue(OP_MTMSR, 0, 0, 0, 8'h00, 4'd0, 32'h1 << PRB);
    check("pr_msr", msr, 32'h0000_4000);
    do_issue(OP_MTSPR, 0, 0, 0, 8'h00, 4'd4, 32'h5555_6666);
    check("priv_fault", 32'(bus.out_fault), 32'd1);
    check("priv_res", bus.out_res, 32'd0);
    do_issue(OP_MFSPR, 0, 0, 0, 8'h00, 4'd4, 32'd0);
    check("priv_rd_fault", 32'(bus.out_fault), 32'd1);
    do_issue(OP_MFSPR, 0, 0, 0, 8'h00, 4'd2, 32'd0);
    check("unpriv_rd_fault", 32'(bus.out_fault), 32'd0);
    do_issue(OP_MTMSR, 0, 0, 0, 8'h00, 4'd0, 32'd0);
    check("mtmsr_fault", 32'(bus.out_fault), 32'd1);
    check("mtmsr_kept", msr, 32'h0000_4000);
    drain();

    // Randomized ops with random back-pressure, two rounds
    for (int r = 0; r < 2; r++) begin
      do_reset();
      rand_ready = 1'b1;
      for (int k = 0; k < 300; k++) begin
        rop = spr_op_e'($urandom_range(0, 14));
        ra  = $urandom;
        if (rop == OP_MTMSR && $urandom_range(0, 7) != 0) ra[PRB] = 1'b0;
        do_issue(rop, 5'($urandom), 5'($urandom), 5'($urandom),
                 8'($urandom), 4'($urandom), ra);
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #2;
      bus.out_ready = 1'b1;
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
